// File: rtl/tortoise_pkg.sv
// Shared frontend types: fetch queue sizing and the record carried from fetch to decode.
package tortoise_pkg;

  localparam int unsigned IFQ_DEPTH       = 8;
  localparam int unsigned INSTR_PER_FETCH = 2;
  localparam int unsigned VLEN            = 32;

  typedef struct packed {
    logic            valid;
    logic [4:0]      cause;
    logic [VLEN-1:0] tval;
  } exception_t;

  typedef struct packed {
    logic            taken;
    logic [VLEN-1:0] target;
  } branch_predict_t;

  typedef struct packed {
    logic            valid;
    logic [VLEN-1:0] addr;
    logic [31:0]     instr;
    exception_t      ex;
    branch_predict_t predict;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Instruction fetch queue: compacts up to LANES sparse pushes per cycle into a circular
// buffer and hands entries to decode one per cycle, in program order.
module fetch_queue
  import tortoise_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH,
  parameter int unsigned LANES = INSTR_PER_FETCH
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  input  logic         [LANES-1:0]      fetch_valid_i,
  input  fetch_entry_t [LANES-1:0]      fetch_entry_i,
  output logic                          fetch_ready_o,
  output logic                          decode_valid_o,
  output fetch_entry_t                  decode_entry_o,
  input  logic                          decode_ack_i,
  output logic [$clog2(DEPTH+1)-1:0]    count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned LW = $clog2(LANES+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LANES_C = CW'(LANES);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  logic [LW-1:0] lane_off [LANES];
  logic [LW-1:0] push_cnt;
  logic [LW-1:0] pushed;
  logic          push_en;
  logic          pop_en;
  fetch_entry_t  stamped [LANES];
  fetch_entry_t  head;

  // Handshake: the frontend push is taken only when fetch_ready_o=1 (a whole LANES-wide
  // slot group is free, judged from the registered count); decode pops when
  // decode_valid_o=1 and decode_ack_i=1. flush_i overrides both in the same cycle.
  assign fetch_ready_o = (DEPTH_C - count) >= LANES_C;
  assign push_en       = fetch_ready_o & ~flush_i;
  assign pop_en        = (count != '0) & decode_ack_i & ~flush_i;

  // Running popcount gives each valid lane its slot offset past wr_ptr.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_off[i] = push_cnt;
      push_cnt    = push_cnt + LW'(fetch_valid_i[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      stamped[i]       = fetch_entry_i[i];
      stamped[i].valid = 1'b1;
    end
  end

  assign pushed     = push_en ? push_cnt : '0;
  assign count_next = count + CW'(pushed) - CW'(pop_en);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(pushed);
      rd_ptr <= rd_ptr + PW'(pop_en);
      count  <= count_next;
    end
  end

  // Storage carries no reset; stale slots are never visible because the head is gated by count.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < LANES; i++) begin
      if (push_en && fetch_valid_i[i]) begin
        mem[wr_ptr + PW'(lane_off[i])] <= stamped[i];
      end
    end
  end

  always_comb begin
    head = mem[rd_ptr];
    if (count == '0) begin
      head = '0;
    end
    head.valid = (count != '0);
  end

  assign decode_entry_o = head;
  assign decode_valid_o = (count != '0);
  assign count_o        = count;

endmodule
